// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter. The width n must match
// the counter instance it is bound to.
interface updown_mod_counter_if #(
   parameter int n = 6
);
   logic         clr;
   logic         en;
   logic         up;
   logic         ld;
   logic [n-1:0] initld;
   logic [n-1:0] cnt;
   logic         co;
   logic         ovf;

   modport master (
      output clr, en, up, ld, initld,
      input  cnt, co, ovf
   );

   modport slave (
      input  clr, en, up, ld, initld,
      output cnt, co, ovf
   );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable terminal value, wrap or saturate
// at the boundary, sticky overflow and a combinational cascade carry-out.
module updown_mod_counter #(
   parameter int          n        = 6,
   parameter int unsigned MAX      = (1 << n) - 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   updown_mod_counter_if.slave  bus
);

   localparam logic [n-1:0] max_v = MAX[n-1:0];

   logic [n-1:0] cnt_q;
   logic         ovf_q;
   logic         at_max;
   logic         at_zero;
   logic         at_bound;

   // Boundary tests are on the current value, so MAX = 2**n-1 never overflows.
   assign at_max   = (cnt_q == max_v);
   assign at_zero  = (cnt_q == '0);
   assign at_bound = bus.up ? at_max : at_zero;

   assign bus.co  = bus.en & ~bus.ld & ~bus.clr & ~rst & at_bound;
   assign bus.cnt = cnt_q;
   assign bus.ovf = ovf_q;

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (bus.ld) begin
         cnt_q <= (bus.initld > max_v) ? max_v : bus.initld;
         ovf_q <= 1'b0;
      end else if (bus.en) begin
         if (at_bound) begin
            ovf_q <= 1'b1;
            if (!SATURATE) begin
               cnt_q <= bus.up ? '0 : max_v;
            end
         end else begin
            cnt_q <= bus.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
         end
      end
   end

endmodule
